// File: rtl/data_mem_bw_if.sv
// data_mem_bw_if: load/store bus between the LSU (master) and data_mem_bw (slave).
//   rd_en/rd_addr      read request and word address
//   rd_data/rd_valid   read result and its qualifier
//   wr_en/wr_addr      write request and word address
//   wr_data/wr_be      write data and per-byte enables
//   init_done          memory zero-fill complete, requests accepted
//   err_oob            one-cycle out-of-range access pulse
interface data_mem_bw_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  init_done;
    logic                  err_oob;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
        input  rd_data, rd_valid, init_done, err_oob
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
        output rd_data, rd_valid, init_done, err_oob
    );
endinterface

// File: rtl/data_mem_bw.sv
// data_mem_bw: word-addressed data memory with byte enables, 1- or 2-cycle
// registered read latency, write-first bypass, out-of-range detection and a
// zero-fill sequence after reset.
//   i_clk      clock, rising edge
//   i_reset_b  synchronous active-low reset
//   i_bus      data_mem_bw_if slave modport (read/write ports, status)
//
// state    | meaning
// ST_INIT  | writing zero to mem[r_cnt], requests ignored
// ST_READY | normal operation, terminal until reset
module data_mem_bw #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_b,
    data_mem_bw_if.slave  i_bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    if ((DATA_W % 8) != 0)                 begin : g_bad_dw  $error("DATA_W must be a multiple of 8"); end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_dp $error("DEPTH must be a power of two >= 2"); end
    if (ADDR_W < IDX_W)                    begin : g_bad_aw  $error("ADDR_W too narrow for DEPTH"); end
    if (READ_LAT != 1 && READ_LAT != 2)    begin : g_bad_lat $error("READ_LAT must be 1 or 2"); end

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_cnt;
    logic                r_init_done;
    logic                r_err_oob;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_rd_oob;
    logic                w_wr_oob;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_wr_hit;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_out_valid;
    logic [DATA_W-1:0]   w_out_data;

    assign w_rd_oob = (i_bus.rd_addr >> IDX_W) != '0;
    assign w_wr_oob = (i_bus.wr_addr >> IDX_W) != '0;
    assign w_rd_idx = i_bus.rd_addr[IDX_W-1:0];
    assign w_wr_idx = i_bus.wr_addr[IDX_W-1:0];
    assign w_rd_acc = (r_state == ST_READY) && i_bus.rd_en;
    assign w_wr_acc = (r_state == ST_READY) && i_bus.wr_en;
    assign w_wr_hit = w_wr_acc && !w_wr_oob && !w_rd_oob && (w_wr_idx == w_rd_idx);

    // Word as seen by a read on this edge: out-of-range reads return zero,
    // a same-address write on the same edge wins for its enabled bytes.
    always_comb begin
        w_rd_word = w_rd_oob ? '0 : r_mem[w_rd_idx];
        if (w_wr_hit) begin
            for (int b = 0; b < NB; b++) begin
                if (i_bus.wr_be[b]) begin
                    w_rd_word[8*b +: 8] = i_bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    // The word is captured on the request edge, so later writes cannot
    // disturb a read already in the pipe.
    if (READ_LAT == 2) begin : g_lat2
        logic              r_p_valid;
        logic [DATA_W-1:0] r_p_data;

        always_ff @(posedge i_clk) begin
            if (!i_reset_b) begin
                r_p_valid <= 1'b0;
                r_p_data  <= '0;
            end else begin
                r_p_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_p_data <= w_rd_word;
                end
            end
        end

        assign w_out_valid = r_p_valid;
        assign w_out_data  = r_p_data;
    end else begin : g_lat1
        assign w_out_valid = w_rd_acc;
        assign w_out_data  = w_rd_word;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_err_oob   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_valid <= w_out_valid;
            if (w_out_valid) begin
                r_rd_data <= w_out_data;
            end
            r_err_oob <= (w_rd_acc && w_rd_oob) || (w_wr_acc && w_wr_oob);
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_state <= ST_READY;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Storage has no reset; the fill sequence makes contents deterministic.
    always_ff @(posedge i_clk) begin
        if (i_reset_b) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_acc && !w_wr_oob) begin
                for (int b = 0; b < NB; b++) begin
                    if (i_bus.wr_be[b]) begin
                        r_mem[w_wr_idx][8*b +: 8] <= i_bus.wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign i_bus.rd_data   = r_rd_data;
    assign i_bus.rd_valid  = r_rd_valid;
    assign i_bus.init_done = r_init_done;
    assign i_bus.err_oob   = r_err_oob;
endmodule

// File: tb/tb_data_mem_bw.sv
// tb_data_mem_bw: directed bench driving a READ_LAT=1 and a READ_LAT=2
// instance of data_mem_bw with identical stimulus.
module tb_data_mem_bw;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_bw_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    data_mem_bw_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    assign bus1.rd_en   = rd_en;
    assign bus1.rd_addr = rd_addr;
    assign bus1.wr_en   = wr_en;
    assign bus1.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data;
    assign bus1.wr_be   = wr_be;
    assign bus2.rd_en   = rd_en;
    assign bus2.rd_addr = rd_addr;
    assign bus2.wr_en   = wr_en;
    assign bus2.wr_addr = wr_addr;
    assign bus2.wr_data = wr_data;
    assign bus2.wr_be   = wr_be;

    data_mem_bw #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(1)) u_dut1 (
        .i_clk     (clk),
        .i_reset_b (rst_b),
        .i_bus     (bus1)
    );

    data_mem_bw #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(2)) u_dut2 (
        .i_clk     (clk),
        .i_reset_b (rst_b),
        .i_bus     (bus2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold illegal requests during the fill; none may produce rd_valid/err_oob.
    task automatic wait_init(input string tag);
        int   cyc  = 0;
        logic seen = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 32'h8000_0000;
        wr_en   = 1'b1;
        wr_addr = 32'd1024;
        wr_data = 32'hFFFF_FFFF;
        wr_be   = 4'hF;
        while (!bus1.init_done && cyc < 2000) begin
            tick();
            cyc++;
            if (bus1.rd_valid || bus2.rd_valid || bus1.err_oob || bus2.err_oob) seen = 1'b1;
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        check({tag, " init cycles"}, 32'(cyc), 32'(DEPTH));
        check({tag, " init_done lat2"}, {31'd0, bus2.init_done}, 32'd1);
        check({tag, " ignored during init"}, {31'd0, seen}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        check({tag, " v1"}, {31'd0, bus1.rd_valid}, 32'd1);
        check({tag, " d1"}, bus1.rd_data, exp);
        check({tag, " v2 early"}, {31'd0, bus2.rd_valid}, 32'd0);
        tick();
        check({tag, " v1 after"}, {31'd0, bus1.rd_valid}, 32'd0);
        check({tag, " v2"}, {31'd0, bus2.rd_valid}, 32'd1);
        check({tag, " d2"}, bus2.rd_data, exp);
    endtask

    initial begin
        rst_b   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;

        tick();
        tick();
        check("rst rd_valid", {30'd0, bus1.rd_valid, bus2.rd_valid}, 32'd0);
        check("rst init_done", {30'd0, bus1.init_done, bus2.init_done}, 32'd0);
        check("rst err_oob", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd0);
        check("rst rd_data1", bus1.rd_data, 32'd0);
        check("rst rd_data2", bus2.rd_data, 32'd0);
        rst_b = 1'b1;
        wait_init("boot");

        rd_chk("fill a0", 32'd0, 32'h0);
        rd_chk("fill a1", 32'd1, 32'h0);
        rd_chk("fill a1023", 32'd1023, 32'h0);

        wr(32'd1, 32'hFFFF_FFFE, 4'hF);
        rd_chk("lat a1", 32'd1, 32'hFFFF_FFFE);

        wr(32'd2, 32'h1122_3344, 4'hF);
        // Back-to-back 1, 2, 1
        rd_en = 1'b1; rd_addr = 32'd1; tick();
        check("b2b c0 v1", {31'd0, bus1.rd_valid}, 32'd1);
        check("b2b c0 d1", bus1.rd_data, 32'hFFFF_FFFE);
        check("b2b c0 v2", {31'd0, bus2.rd_valid}, 32'd0);
        rd_addr = 32'd2; tick();
        check("b2b c1 v1", {31'd0, bus1.rd_valid}, 32'd1);
        check("b2b c1 d1", bus1.rd_data, 32'h1122_3344);
        check("b2b c1 v2", {31'd0, bus2.rd_valid}, 32'd1);
        check("b2b c1 d2", bus2.rd_data, 32'hFFFF_FFFE);
        rd_addr = 32'd1; tick();
        check("b2b c2 v1", {31'd0, bus1.rd_valid}, 32'd1);
        check("b2b c2 d1", bus1.rd_data, 32'hFFFF_FFFE);
        check("b2b c2 d2", bus2.rd_data, 32'h1122_3344);
        rd_en = 1'b0; tick();
        check("b2b c3 v1", {31'd0, bus1.rd_valid}, 32'd0);
        check("b2b c3 d1 hold", bus1.rd_data, 32'hFFFF_FFFE);
        check("b2b c3 v2", {31'd0, bus2.rd_valid}, 32'd1);
        check("b2b c3 d2", bus2.rd_data, 32'hFFFF_FFFE);
        tick();
        check("b2b c4 v2", {31'd0, bus2.rd_valid}, 32'd0);
        check("b2b c4 d2 hold", bus2.rd_data, 32'hFFFF_FFFE);

        wr(32'd2, 32'hAABB_CCDD, 4'b0101);
        rd_chk("be 0101", 32'd2, 32'h11BB_33DD);
        wr(32'd2, 32'h5555_5555, 4'b0000);
        rd_chk("be 0000", 32'd2, 32'h11BB_33DD);

        // Same-address read/write on one edge: write-first
        rd_en = 1'b1; rd_addr = 32'd5;
        wr_en = 1'b1; wr_addr = 32'd5; wr_data = 32'hFFFF_FFFD; wr_be = 4'hF;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check("coll d1", bus1.rd_data, 32'hFFFF_FFFD);
        tick();
        check("coll d2", bus2.rd_data, 32'hFFFF_FFFD);

        // Read in flight is not disturbed by a following write
        rd_en = 1'b1; rd_addr = 32'd5; tick();
        rd_en = 1'b0;
        wr_en = 1'b1; wr_addr = 32'd5; wr_data = 32'h1234_5678; wr_be = 4'hF;
        tick();
        wr_en = 1'b0;
        check("inflight v2", {31'd0, bus2.rd_valid}, 32'd1);
        check("inflight d2", bus2.rd_data, 32'hFFFF_FFFD);
        rd_chk("after inflight", 32'd5, 32'h1234_5678);

        // Out-of-range read
        rd_en = 1'b1; rd_addr = 32'h8000_0000; tick();
        rd_en = 1'b0;
        check("oob rd v1", {31'd0, bus1.rd_valid}, 32'd1);
        check("oob rd d1", bus1.rd_data, 32'h0);
        check("oob rd err", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd3);
        tick();
        check("oob rd v2", {31'd0, bus2.rd_valid}, 32'd1);
        check("oob rd d2", bus2.rd_data, 32'h0);
        check("oob rd err end", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd0);

        // Out-of-range write must not alias onto address 0
        wr(32'd1024, 32'hDEAD_BEEF, 4'hF);
        check("oob wr err", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd3);
        tick();
        check("oob wr err end", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd0);
        rd_chk("oob wr a0", 32'd0, 32'h0);

        // In-range accesses must not flag
        wr(32'd1023, 32'h0000_0001, 4'hF);
        check("inrange no err", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd0);
        rd_chk("a1023 wr", 32'd1023, 32'h0000_0001);

        // Both ports out of range: one single pulse
        rd_en = 1'b1; rd_addr = 32'hFFFF_FFFF;
        wr_en = 1'b1; wr_addr = 32'd2048; wr_data = 32'h0; wr_be = 4'hF;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check("both oob err", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd3);
        tick();
        check("both oob err end", {30'd0, bus1.err_oob, bus2.err_oob}, 32'd0);
        tick();

        // Reset with a read in flight
        wr(32'd3, 32'hCAFE_F00D, 4'hF);
        rd_en = 1'b1; rd_addr = 32'd3; tick();
        rd_en = 1'b0;
        check("mid d1 pre-reset", bus1.rd_data, 32'hCAFE_F00D);
        rst_b = 1'b0;
        tick();
        check("mid rst v", {30'd0, bus1.rd_valid, bus2.rd_valid}, 32'd0);
        check("mid rst init_done", {30'd0, bus1.init_done, bus2.init_done}, 32'd0);
        check("mid rst d2", bus2.rd_data, 32'h0);
        rst_b = 1'b1;
        wait_init("rerun");
        rd_chk("refill a3", 32'd3, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_bw.md
Name: data_mem_bw

Overview:
- Parametrised, word-addressed data memory; successor to the single-cycle data_mem.
- Adds per-byte write enables, a configurable registered read latency (1 or 2) with read-valid, write-first same-address bypass, out-of-range detection, and a hardware zero-fill sequence after reset.
- Sits on the core's load/store path; the LSU gates requests on init_done.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 1024: number of words; must be a power of two, at least 2.
- ADDR_W, 32: address port width in bits; must be at least log2(DEPTH).
- READ_LAT, 1: read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_b  in  1  synchronous, active-low reset.
- rd_en  in  1  read request, sampled on rising edge.
- rd_addr  in  ADDR_W  word address for the read.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds the result of a request.
- wr_en  in  1  write request, sampled on rising edge.
- wr_addr  in  ADDR_W  word address for the write.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i controls wr_data[8i+7:8i].
- init_done  out  1  high once zero-fill is complete; requests accepted only when high.
- err_oob  out  1  one-cycle pulse for an out-of-range access.

Behaviour:
- Reset: reset_b low at a rising edge means:
  - outputs: rd_data=0, rd_valid=0, init_done=0, err_oob=0;
  - read pipeline flushed;
  - FSM enters INIT with fill counter=0.
- Reset asserted mid-INIT or mid-READY restarts the fill from 0.
- FSM has two states, INIT and READY.
  - INIT: each cycle writes mem[cnt]=0 and increments cnt. On the cycle cnt==DEPTH-1 is written, the FSM moves to READY. init_done rises on the next edge, i.e. DEPTH cycles after reset is released.
  - INIT: rd_en and wr_en are ignored, so no rd_valid and no err_oob.
  - READY: terminal state until the next reset.
- Address range: an address is in range when all bits at position log2(DEPTH) and above are 0.
  - Out-of-range write: dropped, memory unchanged.
  - Out-of-range read: still produces rd_valid with rd_data=0.
- err_oob is registered:
  - It pulses 1 cycle after a sampled out-of-range rd_en or wr_en, independent of READ_LAT.
  - Both ports out of range in the same cycle give a single pulse.
- Write (READY, wr_en=1, in range): at the edge, each byte i with wr_be[i]=1 is updated; other bytes hold. wr_be=0 is a legal no-op.
- Read (READY, rd_en=1) sampled at edge N:
  - rd_data and rd_valid appear after edge N+READ_LAT-1, i.e. rd_valid is high for exactly the cycle following edge N+READ_LAT-1.
  - Fully pipelined: one read per cycle, back-to-back reads give contiguous rd_valid.
  - When rd_valid=0, rd_data holds its last value.
- Read-during-write at the same address in the same edge is write-first. Returned word is the old word with the enabled bytes replaced by wr_data.
- Writes on later edges do not alter a read already in flight; it returns the memory state as of its sampling edge.
- Different addresses on the same edge are independent.
- Storage: a plain reg array without reset; the zero-fill provides deterministic contents.

Test Plan:
- Reset, then wait for init:
  - Hold reset_b=0 for 2 edges, release.
  - Required: init_done=0 for exactly DEPTH cycles, then 1.
  - Read addresses 0, 1 and DEPTH-1; each returns 0x00000000 with rd_valid.
- Latency:
  - READ_LAT=1: write 0xFFFFFFFE to address 1, then read address 1; rd_valid and 0xFFFFFFFE appear one cycle after the request edge.
  - Rerun with READ_LAT=2; the same result appears one cycle later.
  - Back-to-back reads of addresses 1, 2, 1 give 3 contiguous valid cycles.
- Byte enables:
  - Address 2 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101.
  - Read of address 2 returns 0x11BB33DD.
  - A further write with wr_be=0 leaves it unchanged.
- Same-address collision:
  - Address 5 holds 0x00000000; on one edge read 5 and write 0xFFFFFFFD with wr_be=4'b1111.
  - Read returns 0xFFFFFFFD.
  - A read of 5 on edge N followed by a write of 0x12345678 to 5 on edge N+1 returns 0xFFFFFFFD with READ_LAT=2.
- Out of range (DEPTH=1024):
  - Write 0xDEADBEEF to address 1024: err_oob pulses for 1 cycle and address 0 still reads 0.
  - Read address 0x80000000: rd_valid with rd_data=0 and one err_oob pulse.
  - Both ports out of range on one edge give a single pulse.
- Reset mid-operation:
  - Write 0xCAFEF00D to address 3, issue a read of 3, then assert reset_b=0 before rd_valid.
  - Required: no rd_valid, init_done drops, zero-fill reruns, and address 3 then reads 0.
